// File: rtl/sampler_multi.sv
// sampler_multi: windowed multi-lane I/Q capture with per-lane demod phase, decimation and integrate mode.
module sampler_multi #(
  parameter int LANES   = 5,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 14,
  parameter int FREQ_W  = 8,
  parameter int LEN_W   = 11,
  parameter int DEC_W   = 6,
  parameter int ACC_W   = 30
) (
  input  logic                       clk100,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic [LANES*DATA_W-1:0]    data_i_in,
  input  logic [LANES*DATA_W-1:0]    data_q_in,
  input  logic [FREQ_W-1:0]          demod_freq,
  input  logic [LEN_W-1:0]           sample_length,
  input  logic [DEC_W-1:0]           sample_freq,
  output logic [LANES*DATA_W-1:0]    data_i_shift,
  output logic [LANES*DATA_W-1:0]    data_q_shift,
  output logic [LANES*PHASE_W-1:0]   phase_vals,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    acc_i,
  output logic signed [ACC_W-1:0]    acc_q,
  output logic                       busy,
  output logic                       done
);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state, state_d;
  logic mode_r;
  logic [LEN_W-1:0] len_r, n;
  logic [DEC_W-1:0] dec_r, dcnt;
  logic [PHASE_W-1:0] base, step;
  logic [PHASE_W-1:0] offs [LANES];
  logic capture, accept;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  always_comb begin
    accept = state == IDLE && start;
    capture = state == COLLECT && dcnt == '0;
    busy = state == COLLECT;
    done = state == DONE;
    state_d = accept ? (sample_length == '0 ? DONE : COLLECT) :
              (state == COLLECT && n == len_r - LEN_W'(1)) ? DONE :
              (state == DONE) ? IDLE : state;
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_i = sum_i + ACC_W'($signed(data_i_in[k*DATA_W +: DATA_W]));
      sum_q = sum_q + ACC_W'($signed(data_q_in[k*DATA_W +: DATA_W]));
    end
  end
  // Lane offsets k*freq are fixed per window, so the per-cycle path is only base+step adds.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state <= IDLE;
      mode_r <= 1'b0;
      len_r <= '0;
      dec_r <= '0;
      n <= '0;
      dcnt <= '0;
      base <= '0;
      step <= '0;
      for (int k = 0; k < LANES; k++) offs[k] <= '0;
      data_i_shift <= '0;
      data_q_shift <= '0;
      phase_vals <= '0;
      out_valid <= 1'b0;
      acc_i <= '0;
      acc_q <= '0;
    end else begin
      state <= state_d;
      out_valid <= capture && !mode_r;
      if (accept) begin
        mode_r <= mode;
        len_r <= sample_length;
        dec_r <= sample_freq == '0 ? DEC_W'(1) : sample_freq;
        n <= '0;
        dcnt <= '0;
        base <= '0;
        step <= PHASE_W'(LANES * demod_freq);
        for (int k = 0; k < LANES; k++) offs[k] <= PHASE_W'(k * demod_freq);
        acc_i <= '0;
        acc_q <= '0;
      end else if (state == COLLECT) begin
        n <= n + LEN_W'(1);
        dcnt <= (dcnt == dec_r - DEC_W'(1)) ? '0 : dcnt + DEC_W'(1);
        base <= base + step;
        if (capture && mode_r) begin
          acc_i <= acc_i + sum_i;
          acc_q <= acc_q + sum_q;
        end
        if (capture && !mode_r) begin
          data_i_shift <= data_i_in;
          data_q_shift <= data_q_in;
          for (int k = 0; k < LANES; k++) phase_vals[k*PHASE_W +: PHASE_W] <= base + offs[k];
        end
      end
    end
  end
endmodule

// File: doc/sampler_multi.md
SAMPLER_MULTI -- requirements
Module: sampler_multi

Interface
REQ-001 Parameter LANES, default 5, parallel samples per clock per channel.
REQ-002 Parameter DATA_W, default 16, signed I/Q sample width.
REQ-003 Parameter PHASE_W, default 14, phase word width.
REQ-004 Parameter FREQ_W, default 8, demod phase-increment width.
REQ-005 Parameter LEN_W, default 11, window length width.
REQ-006 Parameter DEC_W, default 6, decimation factor width.
REQ-007 Parameter ACC_W, default 30, integrator width; SHALL be at least DATA_W+LEN_W+ceil(log2(LANES)).
REQ-008 One clock; reset is synchronous and active-high (clk100, reset).
REQ-009 clk100  input  1  system clock, all logic on rising edge.
REQ-010 reset  input  1  synchronous active-high reset.
REQ-011 start  input  1  one-cycle request to begin a window.
REQ-012 mode  input  1  0 = stream, 1 = integrate.
REQ-013 data_i_in / data_q_in  input  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]; lane 0 is the earliest sample.
REQ-014 demod_freq  input  FREQ_W  phase increment per sample.
REQ-015 sample_length  input  LEN_W  window length in clk100 cycles.
REQ-016 sample_freq  input  DEC_W  capture one cycle in every sample_freq cycles; 0 is treated as 1.
REQ-017 data_i_shift / data_q_shift  output  LANES*DATA_W  captured I/Q lanes.
REQ-018 phase_vals  output  LANES*PHASE_W  per-lane demod phase of the captured cycle.
REQ-019 out_valid  output  1  captured outputs valid this cycle.
REQ-020 acc_i / acc_q  output  ACC_W  signed window sums (integrate mode).
REQ-021 busy  output  1  high in COLLECT.
REQ-022 done  output  1  one-cycle end-of-window pulse.

Function
REQ-023 FSM states: IDLE, COLLECT, DONE; IDLE->COLLECT on start; COLLECT->DONE after the last window cycle; DONE->IDLE unconditionally.
REQ-024 IDLE+start SHALL latch mode, demod_freq, sample_length and sample_freq (0->1) and clear n, the decimation counter and acc_i/acc_q; input changes during a window SHALL have no effect.
REQ-025 start in COLLECT or DONE SHALL be ignored.
REQ-026 sample_length=0 SHALL go IDLE->DONE with no out_valid and acc=0.
REQ-027 Window cycle n runs 0..sample_length-1, where n=0 is the first COLLECT cycle (the cycle after start).
REQ-028 Capture cycle: n mod sample_freq == 0.
REQ-029 Stream mode: a capture at cycle n SHALL register the data and phases and assert out_valid for exactly one cycle at n+1 (latency 1); outputs SHALL hold between captures.
REQ-030 Phase of lane k at cycle n = ((n*LANES+k)*demod_freq) mod 2^PHASE_W, generated by an accumulator stepping LANES*demod_freq per cycle with no multiplier in the cycle path.
REQ-031 Integrate mode: a capture SHALL add the sign-extended sum of all LANES lanes to acc_i/acc_q; out_valid SHALL stay 0.
REQ-032 Integrate mode: acc_i/acc_q SHALL be final in the DONE cycle and hold until the next start or reset.
REQ-033 Stream mode: acc_i/acc_q SHALL remain 0.
REQ-034 done SHALL be high only in DONE; a capture on the last window cycle SHALL produce its out_valid in the same cycle as done.
REQ-035 The phase accumulator SHALL wrap modulo 2^PHASE_W silently.

Reset
REQ-036 reset has priority over all inputs, including start in the same cycle.
REQ-037 reset SHALL force IDLE and set every output to 0 (data_i_shift, data_q_shift, phase_vals, out_valid, acc_i, acc_q, busy, done) on the next edge.
REQ-038 reset mid-COLLECT SHALL abort the window with no done pulse; a start after reset deasserts SHALL be accepted normally.

Verification
REQ-039 Stream, demod_freq=5, sample_freq=1, sample_length=4, ramped data -> 4 consecutive out_valid cycles; first phase_vals = {0,5,10,15,20}; second = {25,...,45}; done with the 4th valid.
REQ-040 sample_freq=5, sample_length=20 -> out_valid after n=0,5,10,15 (4 pulses); sample_freq=0 behaves as 1.
REQ-041 Integrate, all lanes I=+100 and Q=-3, sample_freq=2, sample_length=10 -> acc_i=2500, acc_q=-75 at done; out_valid never asserted.
REQ-042 demod_freq=255, PHASE_W=14 -> phase wraps at 16384 with the exact modulo value; no glitch on out_valid.
REQ-043 reset at n=7 of 20 -> all outputs 0 next cycle, no done; restart completes normally; start pulsed during COLLECT ignored.
REQ-044 sample_length=0 -> done one cycle after start, busy never high.
